// File: rtl/traffic_pkg.sv
// Phase encodings and default dwell durations shared by the intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED_A   = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        ALL_RED_B   = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5
    } phase_e;

    localparam int DEF_CNT_W        = 8;
    localparam int DEF_ALL_RED_T    = 1;
    localparam int DEF_MAIN_MIN_T   = 10;
    localparam int DEF_YELLOW_T     = 3;
    localparam int DEF_SIDE_GREEN_T = 6;

endpackage

// File: rtl/tls_dwell_timer.sv
// Phase dwell counter: loaded with duration-1 on phase entry, counts down on tick,
// saturates at zero and flags expiry on a tick seen at zero.
module tls_dwell_timer #(
    parameter int               CNT_W     = 8,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= RESET_VAL;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - CNT_W'(1);
    end

    assign expired = tick && (count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Timed two-road phase sequencer with latched side/pedestrian requests.
// Optional macro TLS_PED_WALK_EN adds the ped_walk output and its ped_flag latch.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int ALL_RED_T    = DEF_ALL_RED_T,
    parameter int MAIN_MIN_T   = DEF_MAIN_MIN_T,
    parameter int YELLOW_T     = DEF_YELLOW_T,
    parameter int SIDE_GREEN_T = DEF_SIDE_GREEN_T
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       req_pending,
`ifdef TLS_PED_WALK_EN
    output logic       ped_walk,
`endif
    output logic [2:0] phase
);

    localparam longint MAX_T = longint'(1) << CNT_W;

    phase_e           state, next_state;
    logic             load, expired, serve_start, new_req;
    logic [CNT_W-1:0] load_val;

    function automatic logic [CNT_W-1:0] dwell_load(input phase_e p);
        case (p)
            MAIN_GREEN:               return CNT_W'(MAIN_MIN_T - 1);
            MAIN_YELLOW, SIDE_YELLOW: return CNT_W'(YELLOW_T - 1);
            SIDE_GREEN:               return CNT_W'(SIDE_GREEN_T - 1);
            default:                  return CNT_W'(ALL_RED_T - 1);
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ALL_RED_A;
        else
            state <= next_state;
    end

    // Main green only yields once a latched request exists; the timer is simply left at zero.
    always_comb begin
        next_state = state;
        case (state)
            ALL_RED_A:   if (expired) next_state = MAIN_GREEN;
            MAIN_GREEN:  if (expired && req_pending) next_state = MAIN_YELLOW;
            MAIN_YELLOW: if (expired) next_state = ALL_RED_B;
            ALL_RED_B:   if (expired) next_state = SIDE_GREEN;
            SIDE_GREEN:  if (expired) next_state = SIDE_YELLOW;
            SIDE_YELLOW: if (expired) next_state = ALL_RED_A;
            default:     next_state = ALL_RED_A;
        endcase
    end

    assign load     = (next_state != state);
    assign load_val = dwell_load(next_state);

    tls_dwell_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (CNT_W'(ALL_RED_T - 1))
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    assign serve_start = (next_state == SIDE_GREEN) && (state != SIDE_GREEN);
    assign new_req     = (side_req || ped_req) && (state != SIDE_GREEN);

    // Clearing on entry to side green takes priority over a request arriving that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            req_pending <= 1'b0;
        else if (serve_start)
            req_pending <= 1'b0;
        else if (new_req)
            req_pending <= 1'b1;
    end

`ifdef TLS_PED_WALK_EN
    logic ped_flag, walk_q;

    // The walk indication captures ped_flag as side green begins, before the flag is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_flag <= 1'b0;
            walk_q   <= 1'b0;
        end else begin
            if (serve_start)
                ped_flag <= 1'b0;
            else if (ped_req && state != SIDE_GREEN)
                ped_flag <= 1'b1;
            if (serve_start)
                walk_q <= ped_flag;
            else if (next_state != SIDE_GREEN)
                walk_q <= 1'b0;
        end
    end

    assign ped_walk = walk_q;
`endif

    always_comb begin
        main_red    = 1'b1;
        main_yellow = 1'b0;
        main_green  = 1'b0;
        side_red    = 1'b1;
        side_yellow = 1'b0;
        side_green  = 1'b0;
        case (state)
            MAIN_GREEN:  begin main_red = 1'b0; main_green  = 1'b1; end
            MAIN_YELLOW: begin main_red = 1'b0; main_yellow = 1'b1; end
            SIDE_GREEN:  begin side_red = 1'b0; side_green  = 1'b1; end
            SIDE_YELLOW: begin side_red = 1'b0; side_yellow = 1'b1; end
            default: ;
        endcase
    end

    assign phase = state;

    a_durations_legal: assert property (@(posedge clk)
        (ALL_RED_T    >= 1) && (longint'(ALL_RED_T)    <= MAX_T) &&
        (MAIN_MIN_T   >= 1) && (longint'(MAIN_MIN_T)   <= MAX_T) &&
        (YELLOW_T     >= 1) && (longint'(YELLOW_T)     <= MAX_T) &&
        (SIDE_GREEN_T >= 1) && (longint'(SIDE_GREEN_T) <= MAX_T))
        else $error("traffic_phase_scheduler: dwell duration outside 1..2^CNT_W");

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Randomised and directed bench for traffic_phase_scheduler against a tick-counting phase model.
module tb_traffic_phase_scheduler;

    localparam int CNT_W        = 8;
    localparam int ALL_RED_T    = 1;
    localparam int MAIN_MIN_T   = 4;
    localparam int YELLOW_T     = 3;
    localparam int SIDE_GREEN_T = 6;

    logic       clk = 1'b0;
    logic       rst, tick, side_req, ped_req;
    logic       main_red, main_yellow, main_green, side_red, side_yellow, side_green;
    logic       req_pending;
    logic [2:0] phase;
`ifdef TLS_PED_WALK_EN
    logic       ped_walk;
`endif

    traffic_phase_scheduler #(
        .CNT_W        (CNT_W),
        .ALL_RED_T    (ALL_RED_T),
        .MAIN_MIN_T   (MAIN_MIN_T),
        .YELLOW_T     (YELLOW_T),
        .SIDE_GREEN_T (SIDE_GREEN_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .side_req    (side_req),
        .ped_req     (ped_req),
        .main_red    (main_red),
        .main_yellow (main_yellow),
        .main_green  (main_green),
        .side_red    (side_red),
        .side_yellow (side_yellow),
        .side_green  (side_green),
        .req_pending (req_pending),
`ifdef TLS_PED_WALK_EN
        .ped_walk    (ped_walk),
`endif
        .phase       (phase)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit recording = 0;
    int obs_q[$];

    // Reference model: phase index, ticks spent in the phase, and the request latches.
    int m_phase, m_elapsed;
    bit m_pend, m_pedflag, m_walk;
    int dur[6] = '{ALL_RED_T, MAIN_MIN_T, YELLOW_T, ALL_RED_T, SIDE_GREEN_T, YELLOW_T};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] lamps_for(input int p);
        case (p)
            1:       return 6'b001_100;
            2:       return 6'b010_100;
            4:       return 6'b100_001;
            5:       return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_elapsed = 0; m_pend = 0; m_pedflag = 0; m_walk = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input bit p);
        bit adv;
        bit enter_side;
        adv = 0;
        if (t) begin
            m_elapsed++;
            if (m_elapsed >= dur[m_phase] && !(m_phase == 1 && !m_pend))
                adv = 1;
        end
        enter_side = adv && (m_phase == 3);
        if (adv && m_phase == 4) m_walk = 0;
        if (enter_side) m_walk = m_pedflag;
        if (enter_side) begin
            m_pend = 0; m_pedflag = 0;
        end else if (m_phase != 4) begin
            if (s || p) m_pend = 1;
            if (p) m_pedflag = 1;
        end
        if (adv) begin
            m_phase = (m_phase + 1) % 6;
            m_elapsed = 0;
        end
    endtask

    task automatic check_all(input string tag);
        checkOutput({tag, "_phase"}, phase, m_phase);
        checkOutput({tag, "_lamps"}, {main_red, main_yellow, main_green, side_red, side_yellow, side_green},
                    lamps_for(m_phase));
        checkOutput({tag, "_pend"}, req_pending, m_pend);
`ifdef TLS_PED_WALK_EN
        checkOutput({tag, "_walk"}, ped_walk, m_walk);
`endif
    endtask

    task automatic applyStimulus(input bit t, input bit s, input bit p);
        @(negedge clk);
        tick = t; side_req = s; ped_req = p;
        @(posedge clk);
        model_step(t, s, p);
        cyc++;
        #1;
        check_all("cyc");
        if (recording) obs_q.push_back(int'(phase));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; tick = 0; side_req = 0; ped_req = 0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst = 0;
    endtask

    task automatic advanceTo(input int p, input int period, input bit s, output int n);
        n = 0;
        while (int'(phase) != p && n < 400) begin
            applyStimulus((cyc % period) == 0, s, 1'b0);
            n++;
        end
        checkOutput($sformatf("reach_p%0d", p), phase, p);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, w;
        int rp[$];
        int rl[$];
        int exp_p[6] = '{1, 2, 3, 4, 5, 0};
        int exp_l[6] = '{MAIN_MIN_T, YELLOW_T, ALL_RED_T, SIDE_GREEN_T, YELLOW_T, ALL_RED_T};

        rst = 1; tick = 0; side_req = 0; ped_req = 0;
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        rst = 0;

        // Minimum green with a request one cycle into main green, tick tied high.
        recording = 1;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        repeat (18) applyStimulus(1, 0, 0);
        recording = 0;
        foreach (obs_q[i]) begin
            if (i == 0 || obs_q[i] != obs_q[i-1]) begin
                rp.push_back(obs_q[i]);
                rl.push_back(1);
            end else begin
                rl[rl.size()-1]++;
            end
        end
        checkOutput("run_count", rp.size() >= 6, 1);
        for (int k = 0; k < 6 && k < rp.size(); k++) begin
            checkOutput($sformatf("run%0d_phase", k), rp[k], exp_p[k]);
            checkOutput($sformatf("run%0d_len", k), rl[k], exp_l[k]);
        end

        // Asynchronous reset in the middle of side green.
        applyStimulus(1, 1, 0);
        advanceTo(4, 1, 0, n);
        applyStimulus(1, 0, 0);
        do_reset();
        checkOutput("midrst_phase", phase, 0);
        checkOutput("midrst_reds", {main_red, side_red}, 2'b11);

        // Idle main road, then a pedestrian pulse on a non-tick cycle.
        applyStimulus(1, 0, 0);
        repeat (100) applyStimulus(1, 0, 0);
        checkOutput("idle_phase", phase, 1);
        applyStimulus(0, 0, 1);
        checkOutput("idle_pend", req_pending, 1);
        applyStimulus(1, 0, 0);
        checkOutput("idle_exit", phase, 2);

        // Request on the side-green entry cycle is dropped; one in side yellow is kept.
        advanceTo(3, 1, 0, n);
        applyStimulus(1, 1, 0);
        checkOutput("entry_phase", phase, 4);
        checkOutput("entry_pend", req_pending, 0);
        advanceTo(5, 1, 0, n);
        applyStimulus(1, 1, 0);
        checkOutput("yellow_pend", req_pending, 1);
        advanceTo(1, 1, 0, n);
        advanceTo(2, 1, 0, n);
        checkOutput("served_green", n, MAIN_MIN_T);

        // Tick every 5 clocks stretches main yellow to 5*YELLOW_T clocks.
        do_reset();
        advanceTo(2, 5, 1, n);
        advanceTo(3, 5, 0, n);
        checkOutput("gated_yellow", n, 5 * YELLOW_T);

`ifdef TLS_PED_WALK_EN
        do_reset();
        advanceTo(1, 1, 0, n);
        applyStimulus(1, 0, 1);
        advanceTo(4, 1, 0, n);
        w = 0;
        repeat (SIDE_GREEN_T + 3) begin
            if (ped_walk === 1'b1) w++;
            applyStimulus(1, 0, 0);
        end
        checkOutput("walk_len", w, SIDE_GREEN_T);
        advanceTo(1, 1, 0, n);
        applyStimulus(1, 1, 0);
        advanceTo(4, 1, 0, n);
        w = 0;
        repeat (SIDE_GREEN_T + 3) begin
            if (ped_walk !== 1'b0) w++;
            applyStimulus(1, 0, 0);
        end
        checkOutput("walk_side_only", w, 0);
`endif

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                              $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
